// File: rtl/xres_filter.sv
// External reset conditioner: synchronizes and debounces the level-shifted xresb pad,
// stretches the release, and drives a registered active-low core reset.
module xres_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int DEBOUNCE    = 16,
   parameter int STRETCH     = 64,
   parameter int CNT_W       = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             xresb_in,
   input  logic             glitch_clr,
   output logic             core_resetb,
   output logic [1:0]       reset_state,
   output logic [CNT_W-1:0] glitch_count
);

   localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam int SW = (STRETCH > 1) ? $clog2(STRETCH) : 1;
   localparam logic [DW-1:0]    DLIM = DW'(DEBOUNCE - 1);
   localparam logic [SW-1:0]    SLIM = SW'(STRETCH - 1);
   localparam logic [CNT_W-1:0] GMAX = {CNT_W{1'b1}};

   localparam logic [1:0] S_HOLD    = 2'b00;
   localparam logic [1:0] S_STRETCH = 2'b01;
   localparam logic [1:0] S_RUN     = 2'b10;

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   f_q, f_d;
   logic [DW-1:0]          dcnt_q, dcnt_d;
   logic [SW-1:0]          scnt_q, scnt_d;
   logic [1:0]             state_q, state_d;
   logic                   resetb_q, resetb_d;
   logic [CNT_W-1:0]       gcnt_q, gcnt_d;
   logic                   xs;
   logic                   glitch_inc;

   assign xs     = sync_q[SYNC_STAGES-1];
   assign sync_d = {sync_q[SYNC_STAGES-2:0], xresb_in};

   // Debounce: a disagreement must persist DEBOUNCE cycles, shorter runs are counted as glitches.
   always_comb begin
      f_d        = f_q;
      dcnt_d     = dcnt_q;
      glitch_inc = 1'b0;
      if (xs != f_q) begin
         if (dcnt_q == DLIM) begin
            f_d    = xs;
            dcnt_d = '0;
         end else begin
            dcnt_d = dcnt_q + 1'b1;
         end
      end else if (dcnt_q != '0) begin
         dcnt_d     = '0;
         glitch_inc = 1'b1;
      end else begin
         dcnt_d = dcnt_q;
      end
   end

   always_comb begin
      if (glitch_clr) begin
         gcnt_d = '0;
      end else if (glitch_inc && (gcnt_q != GMAX)) begin
         gcnt_d = gcnt_q + 1'b1;
      end else begin
         gcnt_d = gcnt_q;
      end
   end

   // Release sequencing; any drop of the filtered level returns to HOLD.
   always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      case (state_q)
         S_HOLD: begin
            if (f_q) begin
               state_d = S_STRETCH;
               scnt_d  = '0;
            end else begin
               state_d = S_HOLD;
            end
         end
         S_STRETCH: begin
            if (!f_q) begin
               state_d = S_HOLD;
            end else if (scnt_q == SLIM) begin
               state_d = S_RUN;
            end else begin
               scnt_d = scnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (!f_q) begin
               state_d = S_HOLD;
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_HOLD;
         end
      endcase
      resetb_d = (state_d == S_RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q   <= '0;
         f_q      <= 1'b0;
         dcnt_q   <= '0;
         scnt_q   <= '0;
         state_q  <= S_HOLD;
         resetb_q <= 1'b0;
         gcnt_q   <= '0;
      end else begin
         sync_q   <= sync_d;
         f_q      <= f_d;
         dcnt_q   <= dcnt_d;
         scnt_q   <= scnt_d;
         state_q  <= state_d;
         resetb_q <= resetb_d;
         gcnt_q   <= gcnt_d;
      end
   end

   assign core_resetb  = resetb_q;
   assign reset_state  = state_q;
   assign glitch_count = gcnt_q;

endmodule

// File: tb/tb_xres_filter.sv
// Scoreboard bench for xres_filter: default and minimal-latency instances share stimulus,
// each checked every cycle against a run-length reference model.
module tb_xres_filter;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       xresb_in = 1'b0;
   logic       glitch_clr = 1'b0;
   logic       rb_a, rb_b;
   logic [1:0] st_a, st_b;
   logic [7:0] gc_a, gc_b;

   always #5 clock = ~clock;

   xres_filter #(.SYNC_STAGES(2), .DEBOUNCE(16), .STRETCH(64), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .xresb_in(xresb_in), .glitch_clr(glitch_clr),
      .core_resetb(rb_a), .reset_state(st_a), .glitch_count(gc_a));

   xres_filter #(.SYNC_STAGES(3), .DEBOUNCE(1), .STRETCH(1), .CNT_W(8)) dut_b (
      .clock(clock), .reset(reset), .xresb_in(xresb_in), .glitch_clr(glitch_clr),
      .core_resetb(rb_b), .reset_state(st_b), .glitch_count(gc_b));

   typedef struct packed {
      logic       rb;
      logic [1:0] st;
      logic [7:0] gc;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea_m, eb_m;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state: input history, filtered level, disagreement run, high-run length
   int       ss[2] = '{2, 3};
   int       db[2] = '{16, 1};
   int       sl[2] = '{64, 1};
   bit [7:0] hist[2];
   bit       mf[2];
   int       run[2];
   int       hi_len[2];
   int       gcm[2];

   task automatic model_step(input int k, input bit rst, input bit x, input bit clr, output exp_t e);
      bit xs;
      bit f_prev;
      logic [1:0] st;
      if (rst) begin
         hist[k] = 8'd0; mf[k] = 1'b0; run[k] = 0; hi_len[k] = 0; gcm[k] = 0;
         st = 2'b00;
      end else begin
         xs     = hist[k][ss[k]-1];
         f_prev = mf[k];
         if (xs != mf[k]) begin
            run[k] = run[k] + 1;
            if (run[k] == db[k]) begin
               mf[k]  = xs;
               run[k] = 0;
            end
         end else if (run[k] > 0) begin
            run[k] = 0;
            if (gcm[k] < 255) gcm[k] = gcm[k] + 1;
         end
         if (clr) gcm[k] = 0;
         // Release is held until the filtered level has been high for more than STRETCH edges
         if (f_prev) begin
            if (hi_len[k] < 1000) hi_len[k] = hi_len[k] + 1;
         end else begin
            hi_len[k] = 0;
         end
         if (!f_prev)                st = 2'b00;
         else if (hi_len[k] <= sl[k]) st = 2'b01;
         else                        st = 2'b10;
         hist[k] = {hist[k][6:0], x};
      end
      e.rb = (st == 2'b10);
      e.st = st;
      e.gc = gcm[k][7:0];
   endtask

   task automatic tick(input bit x, input bit clr, input bit rst);
      exp_t ea, eb;
      @(negedge clock);
      xresb_in   = x;
      glitch_clr = clr;
      reset      = rst;
      model_step(0, rst, x, clr, ea);
      qa.push_back(ea);
      model_step(1, rst, x, clr, eb);
      qb.push_back(eb);
      @(posedge clock);
      #1;
   endtask

   task automatic hold_level(input bit x, input int n);
      for (int i = 0; i < n; i++) tick(x, 1'b0, 1'b0);
   endtask

   // Monitor: every cycle both DUTs present their outputs; compare against queued expectations
   always @(posedge clock) begin
      #1;
      if (qa.size() > 0) begin
         ea_m = qa.pop_front();
         n_checks++;
         if ({rb_a, st_a, gc_a} !== ea_m) begin
            n_fail++;
            $display("FAIL sb_default t=%0t: got rb=%b st=%b gc=%0d, expected rb=%b st=%b gc=%0d",
                     $time, rb_a, st_a, gc_a, ea_m.rb, ea_m.st, ea_m.gc);
         end
      end
      if (qb.size() > 0) begin
         eb_m = qb.pop_front();
         n_checks++;
         if ({rb_b, st_b, gc_b} !== eb_m) begin
            n_fail++;
            $display("FAIL sb_fast t=%0t: got rb=%b st=%b gc=%0d, expected rb=%b st=%b gc=%0d",
                     $time, rb_b, st_b, gc_b, eb_m.rb, eb_m.st, eb_m.gc);
         end
      end
   end

   initial begin
      int lvl;
      int len;
      // Reset, then release and run well past the stretch
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1);
      hold_level(1'b1, 100);
      // Short low pulse rejected, long one asserts reset, then release again
      hold_level(1'b0, 10);
      hold_level(1'b1, 40);
      hold_level(1'b0, 20);
      hold_level(1'b1, 100);
      // Saturate the glitch counter
      for (int g = 0; g < 300; g++) begin
         hold_level(1'b0, 4);
         hold_level(1'b1, 26);
      end
      // Clear coinciding with a rejection edge
      hold_level(1'b0, 4);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b0, 1'b0);
      tick(1'b1, 1'b1, 1'b0);
      hold_level(1'b1, 30);
      // Release bounce during stretch
      hold_level(1'b0, 30);
      hold_level(1'b1, 48);
      hold_level(1'b0, 20);
      hold_level(1'b1, 100);
      // One-cycle reset mid-RUN with xresb_in high
      tick(1'b1, 1'b0, 1'b1);
      hold_level(1'b1, 100);
      // Single-cycle pulses, accepted by the fast instance
      for (int p = 0; p < 5; p++) begin
         tick(1'b0, 1'b0, 1'b0);
         hold_level(1'b1, 8);
      end
      // Randomized pulse trains with occasional clears and resets
      lvl = 1;
      for (int r = 0; r < 120; r++) begin
         len = ($urandom_range(0, 3) == 0) ? $urandom_range(15, 90) : $urandom_range(1, 18);
         for (int i = 0; i < len; i++) begin
            tick(lvl[0], ($urandom_range(0, 49) == 0), ($urandom_range(0, 799) == 0));
         end
         lvl = 1 - lvl;
      end
      hold_level(1'b1, 100);
      @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
